// File: rtl/carrier_code_accum.sv
// Correlator front end: mixes the IF sample with the NCO I/Q carrier and wipes off the code chip.
// It integrates I/Q between dumps and holds the latched totals behind a valid/ack handshake.
module carrier_code_accum #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_enable,
    input  logic             if_sign,
    input  logic             if_mag,
    input  logic             i_sign,
    input  logic             i_mag,
    input  logic             q_sign,
    input  logic             q_mag,
    input  logic             code,
    input  logic             dump_enable,
    input  logic             dump_ack,
    output logic [ACC_W-1:0] i_dump,
    output logic [ACC_W-1:0] q_dump,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             dump_valid,
    output logic             overrun
);

    localparam int TW = 4;

    // Product of IF, carrier and code; magnitude is one of 1, 2, 3 or 6.
    function automatic logic signed [TW-1:0] mix(
        input logic s,
        input logic m,
        input logic cs,
        input logic cm,
        input logic cd
    );
        logic       neg;
        logic [2:0] mag;
        neg = ~(s ^ cs ^ cd);
        mag = m ? (cm ? 3'd6 : 3'd3) : (cm ? 3'd2 : 3'd1);
        mix = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic signed [TW-1:0] term_i;
    logic signed [TW-1:0] term_q;
    logic                 term_v;
    logic                 dump_d;

    logic [ACC_W-1:0]     i_acc;
    logic [ACC_W-1:0]     q_acc;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_W-1:0]     ext_i;
    logic [ACC_W-1:0]     ext_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            term_i <= '0;
            term_q <= '0;
            term_v <= 1'b0;
            dump_d <= 1'b0;
        end else begin
            term_i <= mix(if_sign, if_mag, i_sign, i_mag, code);
            term_q <= mix(if_sign, if_mag, q_sign, q_mag, code);
            term_v <= sample_enable;
            dump_d <= dump_enable;
        end
    end

    assign ext_i = {{(ACC_W-TW){term_i[TW-1]}}, term_i};
    assign ext_q = {{(ACC_W-TW){term_q[TW-1]}}, term_q};

    // A dump restarts the period with the term that arrives alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_acc      <= '0;
            q_acc      <= '0;
            cnt        <= '0;
            i_dump     <= '0;
            q_dump     <= '0;
            sample_cnt <= '0;
        end else if (dump_d) begin
            i_dump     <= i_acc;
            q_dump     <= q_acc;
            sample_cnt <= cnt;
            i_acc      <= term_v ? ext_i : '0;
            q_acc      <= term_v ? ext_q : '0;
            cnt        <= term_v ? CNT_W'(1) : '0;
        end else if (term_v) begin
            i_acc      <= i_acc + ext_i;
            q_acc      <= q_acc + ext_q;
            cnt        <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (dump_d)
                dump_valid <= 1'b1;
            else if (dump_ack)
                dump_valid <= 1'b0;
            if (dump_d && dump_valid && !dump_ack)
                overrun <= 1'b1;
            else if (dump_ack && dump_valid)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_carrier_code_accum.sv
// Directed bench for carrier_code_accum: mixing, wipe-off, period boundaries,
// wrap, back-to-back dumps, handshake and reset.
module tb_carrier_code_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_enable = 1'b0;
    logic        if_sign = 1'b1;
    logic        if_mag = 1'b1;
    logic        i_sign = 1'b1;
    logic        i_mag = 1'b1;
    logic        q_sign = 1'b0;
    logic        q_mag = 1'b0;
    logic        code = 1'b1;
    logic        dump_enable = 1'b0;
    logic        dump_ack = 1'b0;
    logic [19:0] i_dump;
    logic [19:0] q_dump;
    logic [15:0] sample_cnt;
    logic        dump_valid;
    logic        overrun;
    logic [7:0]  i_dump8;
    logic [7:0]  q_dump8;
    logic [15:0] sample_cnt8;
    logic        dump_valid8;
    logic        overrun8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    carrier_code_accum #(.ACC_W(20), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_enable(sample_enable),
        .if_sign(if_sign), .if_mag(if_mag),
        .i_sign(i_sign), .i_mag(i_mag), .q_sign(q_sign), .q_mag(q_mag),
        .code(code), .dump_enable(dump_enable), .dump_ack(dump_ack),
        .i_dump(i_dump), .q_dump(q_dump), .sample_cnt(sample_cnt),
        .dump_valid(dump_valid), .overrun(overrun)
    );

    carrier_code_accum #(.ACC_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .sample_enable(sample_enable),
        .if_sign(if_sign), .if_mag(if_mag),
        .i_sign(i_sign), .i_mag(i_mag), .q_sign(q_sign), .q_mag(q_mag),
        .code(code), .dump_enable(dump_enable), .dump_ack(dump_ack),
        .i_dump(i_dump8), .q_dump(q_dump8), .sample_cnt(sample_cnt8),
        .dump_valid(dump_valid8), .overrun(overrun8)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic se, input logic de, input logic ack);
        sample_enable = se;
        dump_enable   = de;
        dump_ack      = ack;
        @(posedge clk);
        #1;
    endtask

    function automatic int term(input bit s, input bit m, input bit cs,
                                input bit cm, input bit cd);
        return (s ? 1 : -1) * (m ? 3 : 1) * (cs ? 1 : -1) *
               (cm ? 2 : 1) * (cd ? 1 : -1);
    endfunction

    task automatic basic_carrier();
        if_sign = 1'b1; if_mag = 1'b1;
        i_sign  = 1'b1; i_mag  = 1'b1;
        q_sign  = 1'b0; q_mag  = 1'b0;
        code    = 1'b1;
    endtask

    int pi, pq, pc, li, lq, lc, ti, tq;
    bit se, de, ak;

    initial begin
        basic_carrier();
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        check("rst_i_dump", $signed(i_dump), 0);
        check("rst_q_dump", $signed(q_dump), 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_overrun", overrun, 0);

        // basic mix: I = +3*+2 = 6, Q = +3*-1 = -3
        for (int k = 0; k < 10; k++) step(1, 0, 0);
        step(0, 1, 0);
        check("basic_valid_early", dump_valid, 0);
        step(0, 0, 0);
        check("basic_valid", dump_valid, 1);
        check("basic_i", $signed(i_dump), 60);
        check("basic_q", $signed(q_dump), -30);
        check("basic_cnt", sample_cnt, 10);
        step(0, 0, 1);
        check("basic_ack_valid", dump_valid, 0);
        check("basic_hold_i", $signed(i_dump), 60);

        // code wipe-off
        code = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 0, 0);
        code = 1'b1;
        for (int k = 0; k < 6; k++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("wipe_i", $signed(i_dump), 12);
        check("wipe_q", $signed(q_dump), -6);
        check("wipe_cnt", sample_cnt, 10);
        step(0, 0, 1);

        // gapped samples, dumps coincide with a sample
        pi = 0; pq = 0; pc = 0; li = 0; lq = 0; lc = 0;
        for (int k = 0; k < 32; k++) begin
            se = (k % 2 == 0);
            de = (k == 10 || k == 20 || k == 30);
            ak = (k == 12 || k == 22);
            if_sign = k[1]; if_mag = k[2];
            i_sign = k[3]; i_mag = k[1] ^ k[3];
            q_sign = k[2] ^ k[1]; q_mag = k[4];
            code = k[1] | k[4];
            ti = term(if_sign, if_mag, i_sign, i_mag, code);
            tq = term(if_sign, if_mag, q_sign, q_mag, code);
            if (de) begin
                li = pi; lq = pq; lc = pc;
                pi = se ? ti : 0;
                pq = se ? tq : 0;
                pc = se ? 1 : 0;
            end else if (se) begin
                pi += ti; pq += tq; pc += 1;
            end
            step(se, de, ak);
            if (k == 11 || k == 21 || k == 31) begin
                check($sformatf("gap_i_%0d", k), $signed(i_dump), li);
                check($sformatf("gap_q_%0d", k), $signed(q_dump), lq);
                check($sformatf("gap_cnt_%0d", k), sample_cnt, lc);
            end
        end

        // reset mid-period discards partial sums and in-flight sample
        basic_carrier();
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        rst = 1'b1;
        step(1, 0, 0);
        rst = 1'b0;
        check("mid_rst_i", $signed(i_dump), 0);
        check("mid_rst_q", $signed(q_dump), 0);
        check("mid_rst_cnt", sample_cnt, 0);
        check("mid_rst_valid", dump_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("mid_rst_cnt_after", sample_cnt, 3);
        check("mid_rst_i_after", $signed(i_dump), 18);

        // second dump without ack -> overrun
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("ovr_set", overrun, 1);
        check("ovr_valid", dump_valid, 1);
        check("ovr_i", $signed(i_dump), 12);
        check("ovr_cnt", sample_cnt, 2);
        step(0, 0, 1);
        check("ovr_ack_valid", dump_valid, 0);
        check("ovr_ack_overrun", overrun, 0);
        step(0, 0, 1);
        check("ack_idle_valid", dump_valid, 0);

        // dump and ack on the same edge
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("co_pre_valid", dump_valid, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        check("co_valid", dump_valid, 1);
        check("co_overrun", overrun, 0);
        check("co_cnt", sample_cnt, 3);
        check("co_i", $signed(i_dump), 18);
        step(0, 0, 1);

        // back-to-back dumps
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        check("b2b_first_cnt", sample_cnt, 2);
        step(0, 0, 0);
        check("b2b_second_cnt", sample_cnt, 1);
        check("b2b_second_i", $signed(i_dump), 6);
        step(0, 0, 1);

        // 8-bit wrap: 22 x 6 = 132 -> -124, 22 x -3 = -66
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 22; k++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("wrap_i8", $signed(i_dump8), -124);
        check("wrap_q8", $signed(q_dump8), -66);
        check("wrap_cnt8", sample_cnt8, 22);
        check("wrap_i20", $signed(i_dump), 132);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
